ocx_tlx_oc_responder: RTL and testbench

OCX_TLX_OC_RESPONDER -- requirements
Module: ocx_tlx_oc_responder

---
 rtl/ocx_tlx_axi_pkg.sv | 40 ++++
 rtl/ocx_tlx_credit_ctr.sv | 38 +++
 rtl/ocx_tlx_oc_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_ocx_tlx_oc_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocx_tlx_axi_pkg.sv
// Shared TLX opcodes, AXI response encodings and the response-opcode classifier
// for the OpenCAPI responder.
package ocx_tlx_axi_pkg;

  localparam logic [7:0] OPC_RD_MEM          = 8'h20;
  localparam logic [7:0] OPC_WR_MEM          = 8'h81;
  localparam logic [7:0] OPC_MEM_RD_RESPONSE = 8'h01;
  localparam logic [7:0] OPC_MEM_RD_FAIL     = 8'h02;
  localparam logic [7:0] OPC_MEM_WR_RESPONSE = 8'h04;
  localparam logic [7:0] OPC_MEM_WR_FAIL     = 8'h05;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] RUSER_NONE = 3'b000;
  localparam logic [2:0] RUSER_FAIL = 3'b001;

  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_RD_OK,
    RSP_RD_FAIL,
    RSP_WR_OK,
    RSP_WR_FAIL
  } rsp_kind_e;

  // Classify a TLX response opcode; anything unrecognised is RSP_NONE.
  function automatic rsp_kind_e decode_rsp(input logic [7:0] opcode);
    rsp_kind_e kind;
    kind = RSP_NONE;
    case (opcode)
      OPC_MEM_RD_RESPONSE: kind = RSP_RD_OK;
      OPC_MEM_RD_FAIL:     kind = RSP_RD_FAIL;
      OPC_MEM_WR_RESPONSE: kind = RSP_WR_OK;
      OPC_MEM_WR_FAIL:     kind = RSP_WR_FAIL;
      default:             kind = RSP_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/ocx_tlx_credit_ctr.sv
// Downstream command credit counter: decrement on load, increment on returned
// credit, saturating at CREDITS.
module ocx_tlx_credit_ctr #(
  parameter int unsigned CREDITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       credit_i,
  output logic [3:0] count_o
);

  localparam logic [3:0] MAX_CREDITS = 4'(CREDITS);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load and credit in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (load_i && !credit_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end else if (credit_i && !load_i && (count_q != MAX_CREDITS)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= MAX_CREDITS;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ocx_tlx_oc_responder.sv
// Alternating write/read command issue onto the TLX command channel with
// credit flow control, plus TLX response decode into AXI B/R pulses.
module ocx_tlx_oc_responder
  import ocx_tlx_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned CREDITS    = 8
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,

  input  logic                    oc_write_command_ready,
  input  logic [ADDR_WIDTH-1:0]   oc_write_command_address,
  input  logic [7:0]              oc_write_command_length,
  input  logic [DATA_WIDTH-1:0]   oc_write_command_data,
  input  logic [DATA_WIDTH-1:0]   oc_write_command_data2,
  input  logic [ID_WIDTH-1:0]     oc_write_command_id,
  output logic                    oc_write_command_taken,

  input  logic                    oc_read_command_ready,
  input  logic [ADDR_WIDTH-1:0]   oc_read_command_address,
  input  logic [7:0]              oc_read_command_length,
  input  logic [ID_WIDTH-1:0]     oc_read_command_id,
  output logic                    oc_read_command_taken,

  output logic                    tlx_cmd_valid,
  output logic [7:0]              tlx_cmd_opcode,
  output logic [ADDR_WIDTH-1:0]   tlx_cmd_addr,
  output logic [7:0]              tlx_cmd_dl,
  output logic [ID_WIDTH-1:0]     tlx_cmd_tag,
  output logic [2*DATA_WIDTH-1:0] tlx_cmd_data,
  input  logic                    tlx_cmd_ready,
  input  logic                    tlx_cmd_credit,

  input  logic                    tlx_resp_valid,
  input  logic [7:0]              tlx_resp_opcode,
  input  logic [ID_WIDTH-1:0]     tlx_resp_tag,
  input  logic [DATA_WIDTH-1:0]   tlx_resp_data,

  output logic                    oc_trans_bvalid,
  output logic [ID_WIDTH-1:0]     oc_trans_bid,
  output logic [1:0]              oc_trans_bresp,
  output logic                    oc_trans_rvalid,
  output logic [ID_WIDTH-1:0]     oc_trans_rid,
  output logic [DATA_WIDTH-1:0]   oc_trans_rdata,
  output logic [1:0]              oc_trans_rresp,
  output logic [2:0]              oc_trans_ruser,

  output logic [3:0]              credits_avail,
  output logic                    unexpected_resp
);

  logic [3:0] credits_c;
  logic       can_load_c;
  logic       grant_wr_c;
  logic       grant_rd_c;
  logic       load_c;

  // Set when the next contended grant should go to the write side.
  logic prio_wr_q, prio_wr_d;

  logic                    cmd_valid_q,  cmd_valid_d;
  logic [7:0]              cmd_opcode_q, cmd_opcode_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q,   cmd_addr_d;
  logic [7:0]              cmd_dl_q,     cmd_dl_d;
  logic [ID_WIDTH-1:0]     cmd_tag_q,    cmd_tag_d;
  logic [2*DATA_WIDTH-1:0] cmd_data_q,   cmd_data_d;

  ocx_tlx_credit_ctr #(
    .CREDITS (CREDITS)
  ) u_credit_ctr (
    .clk      (s0_axi_aclk),
    .rst_n    (s0_axi_aresetn),
    .load_i   (load_c),
    .credit_i (tlx_cmd_credit),
    .count_o  (credits_c)
  );

  // Reset gates the grant so nothing is taken while held in reset.
  always_comb begin
    can_load_c = s0_axi_aresetn && (!cmd_valid_q || tlx_cmd_ready) &&
                 (credits_c != 4'd0) &&
                 (oc_write_command_ready || oc_read_command_ready);
    grant_wr_c = can_load_c && oc_write_command_ready &&
                 (!oc_read_command_ready || prio_wr_q);
    grant_rd_c = can_load_c && oc_read_command_ready && !grant_wr_c;
    load_c     = grant_wr_c || grant_rd_c;
  end

  always_comb begin
    prio_wr_d    = prio_wr_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_opcode_d = cmd_opcode_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_dl_d     = cmd_dl_q;
    cmd_tag_d    = cmd_tag_q;
    cmd_data_d   = cmd_data_q;
    if (grant_wr_c) begin
      prio_wr_d    = 1'b0;
      cmd_valid_d  = 1'b1;
      cmd_opcode_d = OPC_WR_MEM;
      cmd_addr_d   = oc_write_command_address;
      cmd_dl_d     = oc_write_command_length;
      cmd_tag_d    = oc_write_command_id;
      cmd_data_d   = {oc_write_command_data2, oc_write_command_data};
    end else if (grant_rd_c) begin
      prio_wr_d    = 1'b1;
      cmd_valid_d  = 1'b1;
      cmd_opcode_d = OPC_RD_MEM;
      cmd_addr_d   = oc_read_command_address;
      cmd_dl_d     = oc_read_command_length;
      cmd_tag_d    = oc_read_command_id;
      cmd_data_d   = '0;
    end else if (cmd_valid_q && tlx_cmd_ready) begin
      cmd_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      prio_wr_q    <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= '0;
      cmd_addr_q   <= '0;
      cmd_dl_q     <= '0;
      cmd_tag_q    <= '0;
      cmd_data_q   <= '0;
    end else begin
      prio_wr_q    <= prio_wr_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_dl_q     <= cmd_dl_d;
      cmd_tag_q    <= cmd_tag_d;
      cmd_data_q   <= cmd_data_d;
    end
  end

  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q,    bid_d;
  logic [1:0]            bresp_q,  bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q,    rid_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic [1:0]            rresp_q,  rresp_d;
  logic [2:0]            ruser_q,  ruser_d;
  logic                  unexp_q,  unexp_d;

  // Response payloads hold between responses; valids are one-cycle pulses.
  always_comb begin
    bvalid_d = 1'b0;
    rvalid_d = 1'b0;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    ruser_d  = ruser_q;
    unexp_d  = unexp_q;
    if (tlx_resp_valid) begin
      case (decode_rsp(tlx_resp_opcode))
        RSP_WR_OK: begin
          bvalid_d = 1'b1;
          bid_d    = tlx_resp_tag;
          bresp_d  = RESP_OKAY;
        end
        RSP_WR_FAIL: begin
          bvalid_d = 1'b1;
          bid_d    = tlx_resp_tag;
          bresp_d  = RESP_SLVERR;
        end
        RSP_RD_OK: begin
          rvalid_d = 1'b1;
          rid_d    = tlx_resp_tag;
          rdata_d  = tlx_resp_data;
          rresp_d  = RESP_OKAY;
          ruser_d  = RUSER_NONE;
        end
        RSP_RD_FAIL: begin
          rvalid_d = 1'b1;
          rid_d    = tlx_resp_tag;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          ruser_d  = RUSER_FAIL;
        end
        default: unexp_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      ruser_q  <= '0;
      unexp_q  <= 1'b0;
    end else begin
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      ruser_q  <= ruser_d;
      unexp_q  <= unexp_d;
    end
  end

  assign oc_write_command_taken = grant_wr_c;
  assign oc_read_command_taken  = grant_rd_c;

  assign tlx_cmd_valid  = cmd_valid_q;
  assign tlx_cmd_opcode = cmd_opcode_q;
  assign tlx_cmd_addr   = cmd_addr_q;
  assign tlx_cmd_dl     = cmd_dl_q;
  assign tlx_cmd_tag    = cmd_tag_q;
  assign tlx_cmd_data   = cmd_data_q;

  assign oc_trans_bvalid = bvalid_q;
  assign oc_trans_bid    = bid_q;
  assign oc_trans_bresp  = bresp_q;
  assign oc_trans_rvalid = rvalid_q;
  assign oc_trans_rid    = rid_q;
  assign oc_trans_rdata  = rdata_q;
  assign oc_trans_rresp  = rresp_q;
  assign oc_trans_ruser  = ruser_q;

  assign credits_avail   = credits_c;
  assign unexpected_resp = unexp_q;

endmodule

// File: tb/tb_ocx_tlx_oc_responder.sv
// Randomised and directed bench for ocx_tlx_oc_responder: two instances
// (CREDITS=8 and CREDITS=2) share stimulus and are compared with a behavioural model.
module tb_ocx_tlx_oc_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_ready, rd_ready, cmd_ready, cmd_credit, rsp_valid;
  logic [63:0] wr_addr, rd_addr, wr_data, wr_data2, rsp_data;
  logic [7:0]  wr_len, rd_len, rsp_op;
  logic [3:0]  wr_id, rd_id, rsp_tag;

  logic         wr_taken [2];
  logic         rd_taken [2];
  logic         c_valid  [2];
  logic [7:0]   c_op     [2];
  logic [63:0]  c_addr   [2];
  logic [7:0]   c_dl     [2];
  logic [3:0]   c_tag    [2];
  logic [127:0] c_data   [2];
  logic         bvalid   [2];
  logic [3:0]   bid      [2];
  logic [1:0]   bresp    [2];
  logic         rvalid   [2];
  logic [3:0]   rid      [2];
  logic [63:0]  rdata    [2];
  logic [1:0]   rresp    [2];
  logic [2:0]   ruser    [2];
  logic [3:0]   cred     [2];
  logic         unexp    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ocx_tlx_oc_responder #(.CREDITS(g == 0 ? 8 : 2)) u_dut (
      .s0_axi_aclk              (clk),
      .s0_axi_aresetn           (rst_n),
      .oc_write_command_ready   (wr_ready),
      .oc_write_command_address (wr_addr),
      .oc_write_command_length  (wr_len),
      .oc_write_command_data    (wr_data),
      .oc_write_command_data2   (wr_data2),
      .oc_write_command_id      (wr_id),
      .oc_write_command_taken   (wr_taken[g]),
      .oc_read_command_ready    (rd_ready),
      .oc_read_command_address  (rd_addr),
      .oc_read_command_length   (rd_len),
      .oc_read_command_id       (rd_id),
      .oc_read_command_taken    (rd_taken[g]),
      .tlx_cmd_valid            (c_valid[g]),
      .tlx_cmd_opcode           (c_op[g]),
      .tlx_cmd_addr             (c_addr[g]),
      .tlx_cmd_dl               (c_dl[g]),
      .tlx_cmd_tag              (c_tag[g]),
      .tlx_cmd_data             (c_data[g]),
      .tlx_cmd_ready            (cmd_ready),
      .tlx_cmd_credit           (cmd_credit),
      .tlx_resp_valid           (rsp_valid),
      .tlx_resp_opcode          (rsp_op),
      .tlx_resp_tag             (rsp_tag),
      .tlx_resp_data            (rsp_data),
      .oc_trans_bvalid          (bvalid[g]),
      .oc_trans_bid             (bid[g]),
      .oc_trans_bresp           (bresp[g]),
      .oc_trans_rvalid          (rvalid[g]),
      .oc_trans_rid             (rid[g]),
      .oc_trans_rdata           (rdata[g]),
      .oc_trans_rresp           (rresp[g]),
      .oc_trans_ruser           (ruser[g]),
      .credits_avail            (cred[g]),
      .unexpected_resp          (unexp[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the command waiting for acceptance on each instance,
  // the credit budget, and which side wins the next tie.
  typedef struct packed {
    logic [7:0]   op;
    logic [63:0]  addr;
    logic [7:0]   dl;
    logic [3:0]   tag;
    logic [127:0] data;
  } cmd_t;

  bit   m_has     [2];
  cmd_t m_cmd     [2];
  int   m_cred    [2];
  bit   m_next_wr [2];
  int   m_max     [2] = '{8, 2};

  bit          e_bv, e_rv, e_unexp;
  logic [3:0]  e_bid, e_rid;
  logic [1:0]  e_bresp, e_rresp;
  logic [2:0]  e_ruser;
  logic [63:0] e_rdata;

  bit g_w [2];
  bit g_r [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_has[k] = 0; m_cmd[k] = '0; m_cred[k] = m_max[k]; m_next_wr[k] = 1;
    end
    e_bv = 0; e_rv = 0; e_unexp = 0;
    e_bid = 0; e_rid = 0; e_bresp = 0; e_rresp = 0; e_ruser = 0; e_rdata = 0;
  endtask

  task automatic model_grant(input int k, output bit gw, output bit gr);
    bit room;
    room = rst_n && (!m_has[k] || cmd_ready) && (m_cred[k] > 0);
    gw = room && wr_ready && (!rd_ready || m_next_wr[k]);
    gr = room && rd_ready && !gw;
  endtask

  task automatic model_clock();
    bit gw, gr;
    for (int k = 0; k < 2; k++) begin
      model_grant(k, gw, gr);
      if (m_has[k] && cmd_ready) m_has[k] = 0;
      if (gw) begin
        m_has[k] = 1;
        m_cmd[k].op = 8'h81; m_cmd[k].addr = wr_addr; m_cmd[k].dl = wr_len;
        m_cmd[k].tag = wr_id; m_cmd[k].data = {wr_data2, wr_data};
        m_next_wr[k] = 0;
      end else if (gr) begin
        m_has[k] = 1;
        m_cmd[k].op = 8'h20; m_cmd[k].addr = rd_addr; m_cmd[k].dl = rd_len;
        m_cmd[k].tag = rd_id; m_cmd[k].data = '0;
        m_next_wr[k] = 1;
      end
      m_cred[k] = m_cred[k] - int'(gw || gr) + int'(cmd_credit);
      if (m_cred[k] > m_max[k]) m_cred[k] = m_max[k];
    end
    e_bv = 0; e_rv = 0;
    if (rsp_valid) begin
      case (rsp_op)
        8'h04: begin e_bv = 1; e_bid = rsp_tag; e_bresp = 2'b00; end
        8'h05: begin e_bv = 1; e_bid = rsp_tag; e_bresp = 2'b10; end
        8'h01: begin e_rv = 1; e_rid = rsp_tag; e_rdata = rsp_data; e_rresp = 2'b00; e_ruser = 3'b000; end
        8'h02: begin e_rv = 1; e_rid = rsp_tag; e_rdata = '0; e_rresp = 2'b10; e_ruser = 3'b001; end
        default: e_unexp = 1;
      endcase
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cmd_valid%0d", k), c_valid[k], m_has[k]);
      if (m_has[k]) begin
        chk($sformatf("cmd_op%0d", k),   c_op[k],   m_cmd[k].op);
        chk($sformatf("cmd_addr%0d", k), c_addr[k], m_cmd[k].addr);
        chk($sformatf("cmd_dl%0d", k),   c_dl[k],   m_cmd[k].dl);
        chk($sformatf("cmd_tag%0d", k),  c_tag[k],  m_cmd[k].tag);
        chk($sformatf("cmd_data%0d", k), c_data[k], m_cmd[k].data);
      end
      chk($sformatf("credits%0d", k), cred[k], 128'(m_cred[k]));
      chk($sformatf("bvalid%0d", k), bvalid[k], e_bv);
      chk($sformatf("bid%0d", k),    bid[k],    e_bid);
      chk($sformatf("bresp%0d", k),  bresp[k],  e_bresp);
      chk($sformatf("rvalid%0d", k), rvalid[k], e_rv);
      chk($sformatf("rid%0d", k),    rid[k],    e_rid);
      chk($sformatf("rdata%0d", k),  rdata[k],  e_rdata);
      chk($sformatf("rresp%0d", k),  rresp[k],  e_rresp);
      chk($sformatf("ruser%0d", k),  ruser[k],  e_ruser);
      chk($sformatf("unexp%0d", k),  unexp[k],  e_unexp);
    end
  endtask

  // One clock: check taken mid-cycle, advance the model, check registers.
  task automatic step();
    bit gw, gr;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_grant(k, gw, gr);
      chk($sformatf("wr_taken%0d", k), wr_taken[k], gw);
      chk($sformatf("rd_taken%0d", k), rd_taken[k], gr);
      g_w[k] = wr_taken[k];
      g_r[k] = rd_taken[k];
    end
    @(posedge clk);
    if (rst_n) model_clock();
    else model_reset();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    wr_ready = 0; rd_ready = 0; cmd_ready = 0; cmd_credit = 0; rsp_valid = 0;
    wr_addr = 0; rd_addr = 0; wr_data = 0; wr_data2 = 0; rsp_data = 0;
    wr_len = 0; rd_len = 0; rsp_op = 0; wr_id = 0; rd_id = 0; rsp_tag = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [7:0] ops [5];
    ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h04; ops[3] = 8'h05; ops[4] = 8'h00;

    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Single write.
    wr_ready = 1; wr_id = 4'd3; wr_addr = 64'h1000; wr_len = 8'd1;
    wr_data = 64'hA; wr_data2 = 64'hB; cmd_ready = 1;
    step();
    chk("single_w_taken", g_w[0], 1'b1);
    chk("single_w_op", c_op[0], 8'h81);
    chk("single_w_tag", c_tag[0], 4'd3);
    chk("single_w_data", c_data[0], {64'hB, 64'hA});
    chk("single_w_cred", cred[0], 4'd7);
    wr_ready = 0;
    step();

    // Alternation with both sides ready.
    do_reset();
    wr_ready = 1; rd_ready = 1; cmd_ready = 1; cmd_credit = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("alt_w%0d", i), g_w[0], (i % 2) == 0);
      chk($sformatf("alt_r%0d", i), g_r[0], (i % 2) == 1);
      chk($sformatf("alt_overlap%0d", i), g_w[0] & g_r[0], 1'b0);
    end
    idle_inputs();
    step();

    // Credit exhaustion on the CREDITS=2 instance.
    do_reset();
    rd_ready = 1; rd_addr = 64'h2000; rd_len = 8'd2; rd_id = 4'd7; cmd_ready = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt += int'(g_r[1]);
    end
    chk("exhaust_taken", 128'(cnt), 128'd2);
    chk("exhaust_cred", cred[1], 4'd0);
    cmd_credit = 1;
    step();
    chk("credit_cycle_no_take", g_r[1], 1'b0);
    step();
    chk("third_take", g_r[1], 1'b1);
    chk("load_credit_same", cred[1], 4'd1);
    idle_inputs();
    step();

    // Responses.
    rsp_valid = 1; rsp_op = 8'h01; rsp_tag = 4'd5; rsp_data = 64'hDEAD;
    step();
    chk("rd_rsp_valid", rvalid[0], 1'b1);
    chk("rd_rsp_id", rid[0], 4'd5);
    chk("rd_rsp_data", rdata[0], 64'hDEAD);
    chk("rd_rsp_resp", rresp[0], 2'b00);
    rsp_op = 8'h05; rsp_tag = 4'd2; rsp_data = 64'h0;
    step();
    chk("wr_rsp_valid", bvalid[0], 1'b1);
    chk("wr_rsp_id", bid[0], 4'd2);
    chk("wr_rsp_resp", bresp[0], 2'b10);
    rsp_op = 8'h33;
    step();
    chk("bad_rsp_bvalid", bvalid[0], 1'b0);
    chk("bad_rsp_rvalid", rvalid[0], 1'b0);
    chk("bad_rsp_sticky", unexp[0], 1'b1);
    rsp_valid = 0;
    step();

    // Asynchronous reset with a command stuck downstream.
    do_reset();
    wr_ready = 1; wr_addr = 64'h3000; wr_id = 4'd9; cmd_ready = 0;
    step();
    wr_ready = 0;
    step();
    chk("pending_before_rst", c_valid[0], 1'b1);
    wr_ready = 1; rd_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_drop%0d", k), c_valid[k], 1'b0);
      chk($sformatf("rst_no_wtake%0d", k), wr_taken[k], 1'b0);
      chk($sformatf("rst_no_rtake%0d", k), rd_taken[k], 1'b0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    chk("rst_hold_wtake", wr_taken[0], 1'b0);
    rst_n = 1'b1;
    #1;
    chk("cred_after_rel0", cred[0], 4'd8);
    chk("cred_after_rel1", cred[1], 4'd2);
    idle_inputs();
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      wr_ready   = 1'($urandom_range(0, 1));
      rd_ready   = 1'($urandom_range(0, 1));
      cmd_ready  = ($urandom_range(0, 3) != 0);
      cmd_credit = ($urandom_range(0, 2) == 0);
      wr_addr  = {$urandom, $urandom};
      rd_addr  = {$urandom, $urandom};
      wr_data  = {$urandom, $urandom};
      wr_data2 = {$urandom, $urandom};
      wr_len = 8'($urandom); rd_len = 8'($urandom);
      wr_id  = 4'($urandom); rd_id  = 4'($urandom);
      rsp_valid = 1'($urandom_range(0, 1));
      rsp_op    = ops[$urandom_range(0, 4)];
      rsp_tag   = 4'($urandom);
      rsp_data  = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
